// File: rtl/multu_pkg.sv
// Shared definitions for the sequential unsigned multiplier:
// default width, FSM states and the HI/LO read-select encodings.
package multu_pkg;

  localparam int MULTU_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_DONE     = 2'd2,
    ST_WAIT_LOW = 2'd3
  } state_t;

  localparam logic [1:0] HILO_HI = 2'b01;
  localparam logic [1:0] HILO_LO = 2'b10;

endpackage

// File: rtl/multu_shift_add.sv
// One shift-add iteration: conditionally add the multiplicand into the upper
// half of the partial product (keeping the carry), then shift right by one.
module multu_shift_add #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0]  i_p,
  input  logic [WIDTH-1:0]  i_mcand,
  output logic [2*WIDTH:0]  o_p
);

  logic [WIDTH:0] w_upper;

  // The carry out of the add lands in the top bit and is shifted back into range.
  assign w_upper = i_p[0] ? ({1'b0, i_p[2*WIDTH-1:WIDTH]} + {1'b0, i_mcand})
                          : i_p[2*WIDTH:WIDTH];

  assign o_p = {1'b0, w_upper, i_p[WIDTH-1:1]};

endmodule

// File: rtl/multu_seq.sv
// Sequential 32-iteration unsigned multiplier with HI/LO product registers
// and a combinational MFHI/MFLO read mux.
module multu_seq
  import multu_pkg::*;
#(
  parameter int WIDTH = MULTU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       hilo_sel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_next_state;
  logic [2*WIDTH:0] r_p;
  logic [2*WIDTH:0] w_p_step;
  logic [WIDTH-1:0] r_mcand;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             w_last;

  multu_shift_add #(.WIDTH(WIDTH)) u_step (
    .i_p     (r_p),
    .i_mcand (r_mcand),
    .o_p     (w_p_step)
  );

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:     if (start)  w_next_state = ST_RUN;
      ST_RUN:      if (w_last) w_next_state = ST_DONE;
      ST_DONE:     w_next_state = start ? ST_WAIT_LOW : ST_IDLE;
      ST_WAIT_LOW: if (!start) w_next_state = ST_IDLE;
      default:     w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample their inputs from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: these are a handful of flops rather than a memory array, so clearing
  // them all on reset costs nothing and makes an aborted run leave no trace.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p     <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mcand <= a;
            r_p     <= {1'b0, {WIDTH{1'b0}}, b};
            r_cnt   <= '0;
          end
        end
        ST_RUN: begin
          r_p   <= w_p_step;
          r_cnt <= r_cnt + 1'b1;
          // HI/LO hold the old product until the final iteration edge.
          if (w_last) {r_hi, r_lo} <= w_p_step[2*WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (hilo_sel)
      HILO_HI: rdata = r_hi;
      HILO_LO: rdata = r_lo;
      default: rdata = '0;
    endcase
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);

endmodule

// File: doc/multu_seq.md
# multu_seq

Sequential 32-bit unsigned multiplier that responds to the MULTU start signal and HI/LO read-select produced by the ALU control unit. It sits beside the ALU in the execute stage. On a start request it captures both operands and runs a 32-iteration shift-add. It then holds the 64-bit product in HI/LO registers, which MFHI/MFLO read through a select mux.

## Interface
Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock; every register updates on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  multiply request (the MULTU control signal); may be held high for many cycles.
- a  input  WIDTH  multiplicand; sampled only at launch.
- b  input  WIDTH  multiplier; sampled only at launch.
- hilo_sel  input  2  read select: 2'b01 selects HI, 2'b10 selects LO, any other value selects zero.
- hi  output  WIDTH  upper product half, registered.
- lo  output  WIDTH  lower product half, registered.
- rdata  output  WIDTH  combinational mux of hi/lo chosen by hilo_sel.
- busy  output  1  high while iterations are in progress.
- done  output  1  one-cycle pulse when hi/lo have just been updated.

## Operation
- States: IDLE, RUN, DONE, WAIT_LOW.
- IDLE:
  - When start=1 at a clock edge: capture mcand<=a and P<={1'b0, WIDTH'b0, b} (P is 2*WIDTH+1 bits).
  - Set cnt<=0 and go to RUN.
- RUN, each edge:
  - If P[0]=1, the upper WIDTH+1 bits become P[2*WIDTH-1:WIDTH]+mcand, including the carry.
  - Then shift P right by 1 and increment cnt.
  - On the edge where cnt reaches WIDTH-1 (the last iteration), write {hi,lo}<=final P[2*WIDTH-1:0] and go to DONE.
- DONE: lasts one cycle. If start=1 go to WAIT_LOW, otherwise go to IDLE.
- WAIT_LOW: stay until start=0, then go to IDLE. A held start therefore launches exactly one operation.
- Arithmetic is unsigned and exact. The product never overflows 2*WIDTH bits; the extra carry bit is internal only.
- start falling during RUN has no effect. There is no abort except rst.
- Changes on a or b after launch have no effect.
- hi/lo keep their previous values until the final iteration edge. Reading during busy returns the old product.
- rdata is combinational from the registered hi/lo, so it is valid in the same cycle hilo_sel changes.
- rst at any time, including mid-RUN:
  - State goes to IDLE immediately.
  - hi, lo, P, mcand and cnt all clear to 0; busy=0, done=0.
  - The first start after rst release launches normally.

## Timing
- Reset values: hi=0, lo=0, rdata=0, busy=0, done=0, state=IDLE.
- Launch edge E0 is the first edge in IDLE with start=1. busy is high from E0 through E32, i.e. for 32 cycles.
- Iterations occur at edges E1..E32. hi/lo take their new values at E32.
- done is high for the one cycle after E32; busy=0 in that cycle.
- Latency from start being sampled to a valid result is 33 edges. This fits the controller's 34-cycle MULTU window.
- Minimum spacing between launches is 34 edges: E0, 32 iterations, DONE, then IDLE sampling start again. A further cycle is needed if start must first drop through WAIT_LOW.

## Structure
- Package multu_pkg contains:
  - WIDTH default.
  - State enum: IDLE, RUN, DONE, WAIT_LOW.
  - HILO_HI=2'b01, HILO_LO=2'b10.
- One natural sub-module, multu_shift_add: a combinational single-iteration step (P, mcand -> next P). The top level holds the FSM, the counter, the P/mcand registers and the HI/LO registers plus the read mux.

## Test plan
- Reset: assert rst with random inputs -> hi=lo=rdata=0, busy=done=0. Assert rst again mid-run at iteration 10 -> busy drops in the same cycle, hi=lo=0.
- Basic multiply: a=3, b=5, start for one cycle -> busy for 32 cycles, done pulse at E32+1, hi=0, lo=15. With hilo_sel=01, rdata=0; with hilo_sel=10, rdata=15.
- Maximum operands: a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Carry path exercised.
- Held start: start high for 34 cycles, a=7, b=6 -> exactly one done pulse and lo=42. Drop start, then start with a=0x80000000, b=2 -> second done, hi=1, lo=0.
- Operand isolation: launch a=0x10000, b=0x10000, then change a and b every cycle during RUN -> hi=1, lo=0. During busy, rdata still shows the previous product.
- Select boundaries: hilo_sel=00 or 11 -> rdata=0 at all times. Restart after a reset abort with a=9, b=9 -> lo=81.
